// File: rtl/transposer_buf_port_if.sv
// Engine and host bus bundle for the transposer buffer responder.
interface transposer_buf_port_if #(
  parameter int unsigned AW    = 16,
  parameter int unsigned BUFFD = 64
);
  localparam int unsigned DW = BUFFD * 8;

  // Engine read channel
  logic [AW-1:0] raddr;
  logic          raddr_vld;
  logic [DW-1:0] rdata;
  logic          rdata_vld;

  // Engine write channel
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wdata_vld;

  // Host preload/dump channel
  logic          hst_req;
  logic          hst_we;
  logic [AW-1:0] hst_addr;
  logic [DW-1:0] hst_wdata;
  logic          hst_ready;
  logic [DW-1:0] hst_rdata;
  logic          hst_rdata_vld;

  // Status
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_cnt;
  logic          err_oor;

  modport master (
    output raddr, raddr_vld, waddr, wdata, wdata_vld,
           hst_req, hst_we, hst_addr, hst_wdata,
    input  rdata, rdata_vld, hst_ready, hst_rdata, hst_rdata_vld,
           rd_cnt, wr_cnt, err_oor
  );

  modport slave (
    input  raddr, raddr_vld, waddr, wdata, wdata_vld,
           hst_req, hst_we, hst_addr, hst_wdata,
    output rdata, rdata_vld, hst_ready, hst_rdata, hst_rdata_vld,
           rd_cnt, wr_cnt, err_oor
  );
endinterface

// File: rtl/transposer_buf_port.sv
// Engine-side 1R1W buffer with fixed read latency and an arbitrated host port.
// The engine has no backpressure, so host accesses only use idle ports.
module transposer_buf_port #(
  parameter int unsigned AW    = 16,
  parameter int unsigned BUFFD = 64,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned RLAT  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic init_pulse,
  transposer_buf_port_if.slave bus
);

  localparam int unsigned DW   = BUFFD * 8;
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  // One read-pipeline slot: source tag plus data
  typedef struct packed {
    logic          eng;
    logic          hst;
    logic [DW-1:0] data;
  } rd_ent_t;

  logic [DW-1:0] mem [DEPTH];

  logic            hst_rd;
  logic            hst_wr;
  logic            rd_en;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rd_oor;
  logic            wr_oor;
  logic [IDXW-1:0] rd_idx;
  logic [IDXW-1:0] wr_idx;
  logic            oor_hit;
  rd_ent_t         cur;
  rd_ent_t         tail;

  // Host takes a port only when the engine leaves it idle
  assign hst_rd        = bus.hst_req & ~bus.hst_we & ~bus.raddr_vld;
  assign hst_wr        = bus.hst_req &  bus.hst_we & ~bus.wdata_vld;
  assign bus.hst_ready = hst_rd | hst_wr;

  // Port muxing: engine has priority on each port
  assign rd_en   = bus.raddr_vld | hst_rd;
  assign wr_en   = bus.wdata_vld | hst_wr;
  assign rd_addr = bus.raddr_vld ? bus.raddr : bus.hst_addr;
  assign wr_addr = bus.wdata_vld ? bus.waddr : bus.hst_addr;
  assign wr_data = bus.wdata_vld ? bus.wdata : bus.hst_wdata;

  assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_X);
  assign wr_oor  = ({1'b0, wr_addr} >= DEPTH_X);
  assign rd_idx  = rd_addr[IDXW-1:0];
  assign wr_idx  = wr_addr[IDXW-1:0];
  assign oor_hit = (rd_en & rd_oor) | (wr_en & wr_oor);

  // Read lookup with write-first bypass; out-of-range reads return zero
  always_comb begin
    cur      = '0;
    cur.eng  = bus.raddr_vld;
    cur.hst  = hst_rd;
    if (rd_en && !rd_oor) begin
      if (wr_en && !wr_oor && (wr_addr == rd_addr)) cur.data = wr_data;
      else                                          cur.data = mem[rd_idx];
    end
  end

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en && !wr_oor) mem[wr_idx] <= wr_data;
  end

  // Delay line covering all but the final (output) register stage
  generate
    if (RLAT == 1) begin : g_direct
      assign tail = cur;
    end else begin : g_pipe
      rd_ent_t st [RLAT-1];

      // Shift read slots toward the output registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < RLAT - 1; i++) st[i] <= '0;
        end else begin
          st[0] <= cur;
          for (int unsigned i = 1; i < RLAT - 1; i++) st[i] <= st[i-1];
        end
      end

      assign tail = st[RLAT-2];
    end
  endgenerate

  // Output registers: steer each slot to its source, hold data when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rdata         <= '0;
      bus.rdata_vld     <= 1'b0;
      bus.hst_rdata     <= '0;
      bus.hst_rdata_vld <= 1'b0;
    end else begin
      bus.rdata_vld     <= tail.eng;
      bus.hst_rdata_vld <= tail.hst;
      if (tail.eng) bus.rdata     <= tail.data;
      if (tail.hst) bus.hst_rdata <= tail.data;
    end
  end

  // Engine traffic counters and sticky out-of-range flag; init wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_cnt  <= '0;
      bus.wr_cnt  <= '0;
      bus.err_oor <= 1'b0;
    end else if (init_pulse) begin
      bus.rd_cnt  <= '0;
      bus.wr_cnt  <= '0;
      bus.err_oor <= 1'b0;
    end else begin
      if (bus.raddr_vld) bus.rd_cnt <= bus.rd_cnt + AW'(1);
      if (bus.wdata_vld) bus.wr_cnt <= bus.wr_cnt + AW'(1);
      if (oor_hit)       bus.err_oor <= 1'b1;
    end
  end

endmodule
